// File: rtl/interrupt_unit.sv
// Interrupt front end: synchronises and edge-detects IRQ/NMI lines, holds pending
// requests and runs the request/acknowledge/return handshake with the controller.
module interrupt_unit #(
    parameter int N  = 4,
    parameter int VW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  IRQ,
    input  logic          NMIIn,
    input  logic          MaskWe,
    input  logic [N-1:0]  MaskIn,
    input  logic          GieWe,
    input  logic          GieIn,
    input  logic          IntAck,
    input  logic          IntRet,
    output logic          INT,
    output logic          INTD,
    output logic          NMI,
    output logic [VW-1:0] IntVec,
    output logic [N-1:0]  Pending
);

    localparam int L = N + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        SERVICE = 2'd2
    } state_t;

    logic [L-1:0]  raw_in;
    logic [L-1:0]  sync1_q;
    logic [L-1:0]  sync2_q;
    logic [L-1:0]  prev_q;
    logic [L-1:0]  hold_q;
    logic [L-1:0]  hold_d;
    logic [L-1:0]  edge_d;
    logic [1:0]    settle_q;
    logic [1:0]    settle_d;

    state_t        state_q;
    state_t        state_d;
    logic [N-1:0]  pend_q;
    logic [N-1:0]  pend_d;
    logic [N-1:0]  mask_q;
    logic [N-1:0]  mask_d;
    logic [N-1:0]  eligible;
    logic [N-1:0]  clear_vec;
    logic          gie_q;
    logic          gie_d;
    logic          int_q;
    logic          int_d;
    logic          intd_q;
    logic          intd_d;
    logic          nmi_q;
    logic          nmi_d;
    logic [VW-1:0] vec_q;
    logic [VW-1:0] vec_d;
    logic [VW-1:0] winner;

    assign raw_in   = {NMIIn, IRQ};
    assign settle_d = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;

    // hold_q remembers lines already high when reset released, so they only
    // produce an edge after having been seen low at least once.
    genvar gi;
    generate
        for (gi = 0; gi < L; gi++) begin : g_line
            assign edge_d[gi] = sync2_q[gi] & ~prev_q[gi] & ~hold_q[gi];
            assign hold_d[gi] = (settle_q == 2'd1) ? sync1_q[gi] :
                                (settle_q == 2'd2) ? (hold_q[gi] & sync2_q[gi]) :
                                hold_q[gi];
        end
    endgenerate

    assign eligible = pend_q & ~mask_q;

    always_comb begin
        winner = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = VW'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        clear_vec = '0;
        mask_d    = MaskWe ? MaskIn : mask_q;
        gie_d     = GieWe ? GieIn : gie_q;
        case (state_q)
            IDLE: begin
                if ((|eligible) && !intd_q) begin
                    state_d = REQUEST;
                    vec_d   = winner;
                end
            end
            REQUEST: begin
                if (IntAck) begin
                    clear_vec[vec_q] = 1'b1;
                    state_d          = SERVICE;
                end else if (mask_q[vec_q] || !gie_q) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (IntRet) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A fresh edge in the same cycle as the acknowledge clear is a new event.
        pend_d = (pend_q & ~clear_vec) | edge_d[N-1:0];
        int_d  = (state_d == REQUEST);
        intd_d = ~gie_d | (state_d == SERVICE);
        nmi_d  = edge_d[N];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            prev_q   <= '0;
            hold_q   <= '0;
            settle_q <= 2'd0;
            state_q  <= IDLE;
            pend_q   <= '0;
            mask_q   <= '1;
            gie_q    <= 1'b0;
            int_q    <= 1'b0;
            intd_q   <= 1'b1;
            nmi_q    <= 1'b0;
            vec_q    <= '0;
        end else begin
            sync1_q  <= raw_in;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            hold_q   <= hold_d;
            settle_q <= settle_d;
            state_q  <= state_d;
            pend_q   <= pend_d;
            mask_q   <= mask_d;
            gie_q    <= gie_d;
            int_q    <= int_d;
            intd_q   <= intd_d;
            nmi_q    <= nmi_d;
            vec_q    <= vec_d;
        end
    end

    assign INT     = int_q;
    assign INTD    = intd_q;
    assign NMI     = nmi_q;
    assign IntVec  = vec_q;
    assign Pending = pend_q;

endmodule

// File: tb/tb_interrupt_unit.sv
// Self-checking bench for interrupt_unit: directed handshake scenarios plus a
// randomized run compared against an event-level reference model.
module tb_interrupt_unit;

    localparam int N  = 4;
    localparam int VW = 2;
    localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  IRQ;
    logic          NMIIn;
    logic          MaskWe;
    logic [N-1:0]  MaskIn;
    logic          GieWe;
    logic          GieIn;
    logic          IntAck;
    logic          IntRet;
    logic          INT;
    logic          INTD;
    logic          NMI;
    logic [VW-1:0] IntVec;
    logic [N-1:0]  Pending;

    int n_cmp = 0;
    int n_bad = 0;

    interrupt_unit #(.N(N), .VW(VW)) dut (
        .clk(clk), .reset(reset), .IRQ(IRQ), .NMIIn(NMIIn),
        .MaskWe(MaskWe), .MaskIn(MaskIn), .GieWe(GieWe), .GieIn(GieIn),
        .IntAck(IntAck), .IntRet(IntRet), .INT(INT), .INTD(INTD), .NMI(NMI),
        .IntVec(IntVec), .Pending(Pending)
    );

    always #5 clk = ~clk;

    // Reference model: an edge on a line is "sample k-2 high, sample k-3 low",
    // counting samples from the first edge after reset; the first sample never
    // counts as a rise.
    logic          m_int, m_intd, m_nmi, m_gie;
    logic [VW-1:0] m_vec;
    logic [N-1:0]  m_pend, m_mask;
    int            m_phase;
    int            k_post;
    logic [N:0]    hist[$];

    always @(posedge clk) begin : model
        logic [N:0]   edges;
        logic [N-1:0] elig;
        logic [N-1:0] oh;
        logic [N-1:0] clr;
        int           nphase;
        logic [VW-1:0] nvec;
        if (reset) begin
            m_pend = '0; m_mask = '1; m_gie = 1'b0; m_phase = 0;
            m_int = 1'b0; m_intd = 1'b1; m_nmi = 1'b0; m_vec = '0;
            k_post = 0;
            hist = {};
            hist.push_back('0);
        end else begin
            k_post++;
            hist.push_back({NMIIn, IRQ});
            edges = (k_post >= 4) ? (hist[k_post-2] & ~hist[k_post-3]) : '0;
            elig   = m_pend & ~m_mask;
            nphase = m_phase;
            nvec   = m_vec;
            clr    = '0;
            case (m_phase)
                0: if (elig != '0 && !m_intd) begin
                    oh     = elig & (~elig + ONE_N);
                    nvec   = VW'($clog2(oh));
                    nphase = 1;
                end
                1: if (IntAck) begin
                    clr    = ONE_N << m_vec;
                    nphase = 2;
                end else if (m_mask[m_vec] || !m_gie) begin
                    nphase = 0;
                end
                default: if (IntRet) nphase = 0;
            endcase
            m_pend = (m_pend & ~clr) | edges[N-1:0];
            if (MaskWe) m_mask = MaskIn;
            if (GieWe)  m_gie  = GieIn;
            m_phase = nphase;
            m_vec   = nvec;
            m_int   = (nphase == 1);
            m_intd  = !m_gie || (nphase == 2);
            m_nmi   = edges[N];
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        IRQ = '0; NMIIn = 1'b0; MaskWe = 1'b0; MaskIn = '0;
        GieWe = 1'b0; GieIn = 1'b0; IntAck = 1'b0; IntRet = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        IRQ   = 4'b0001;
        tick(); tick();
        n_cmp++;
        if ({INT, INTD, NMI, IntVec, Pending} !== 9'b0_1_0_00_0000) begin
            n_bad++;
            $display("FAIL reset_state got %b want %b", {INT, INTD, NMI, IntVec, Pending}, 9'b0_1_0_00_0000);
        end
        reset = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        n_cmp++;
        if (Pending !== 4'b0000) begin
            n_bad++;
            $display("FAIL held_through_reset got %b want %b", Pending, 4'b0000);
        end
        IRQ = '0;
        tick(); tick();
        $display("test_reset: done");
    endtask

    task automatic test_basic();
        MaskWe = 1'b1; MaskIn = 4'b0000; GieWe = 1'b1; GieIn = 1'b1;
        tick();
        MaskWe = 1'b0; GieWe = 1'b0;
        n_cmp++;
        if (INTD !== 1'b0) begin
            n_bad++; $display("FAIL basic_intd_enabled got %b want %b", INTD, 1'b0);
        end
        IRQ = 4'b0100; tick();
        IRQ = 4'b0000; tick(); tick();
        n_cmp++;
        if ({Pending, INT} !== {4'b0100, 1'b0}) begin
            n_bad++; $display("FAIL basic_pending_edge3 got %b want %b", {Pending, INT}, {4'b0100, 1'b0});
        end
        tick();
        n_cmp++;
        if ({INT, IntVec} !== {1'b1, 2'd2}) begin
            n_bad++; $display("FAIL basic_int_edge4 got %b want %b", {INT, IntVec}, {1'b1, 2'd2});
        end
        IntAck = 1'b1; tick(); IntAck = 1'b0;
        n_cmp++;
        if ({Pending, INT, INTD} !== {4'b0000, 1'b0, 1'b1}) begin
            n_bad++; $display("FAIL basic_ack got %b want %b", {Pending, INT, INTD}, {4'b0000, 1'b0, 1'b1});
        end
        IntRet = 1'b1; tick(); IntRet = 1'b0;
        n_cmp++;
        if ({INT, INTD} !== 2'b00) begin
            n_bad++; $display("FAIL basic_ret got %b want %b", {INT, INTD}, 2'b00);
        end
        $display("test_basic: IRQ2 request/ack/return");
    endtask

    task automatic test_priority();
        IRQ = 4'b1010; tick();
        IRQ = 4'b0000; tick(); tick(); tick();
        n_cmp++;
        if ({INT, IntVec, Pending} !== {1'b1, 2'd1, 4'b1010}) begin
            n_bad++; $display("FAIL prio_first got %b want %b", {INT, IntVec, Pending}, {1'b1, 2'd1, 4'b1010});
        end
        IntAck = 1'b1; tick(); IntAck = 1'b0;
        n_cmp++;
        if ({INT, Pending} !== {1'b0, 4'b1000}) begin
            n_bad++; $display("FAIL prio_ack got %b want %b", {INT, Pending}, {1'b0, 4'b1000});
        end
        IntRet = 1'b1; tick(); IntRet = 1'b0;
        tick();
        n_cmp++;
        if ({INT, IntVec} !== {1'b1, 2'd3}) begin
            n_bad++; $display("FAIL prio_second got %b want %b", {INT, IntVec}, {1'b1, 2'd3});
        end
        IntAck = 1'b1; tick(); IntAck = 1'b0;
        IntRet = 1'b1; tick(); IntRet = 1'b0;
        n_cmp++;
        if ({INT, INTD, Pending} !== {1'b0, 1'b0, 4'b0000}) begin
            n_bad++; $display("FAIL prio_done got %b want %b", {INT, INTD, Pending}, {1'b0, 1'b0, 4'b0000});
        end
        $display("test_priority: IRQ1 then IRQ3");
    endtask

    task automatic test_mask();
        MaskWe = 1'b1; MaskIn = 4'b0010; tick(); MaskWe = 1'b0;
        IRQ = 4'b0010; tick();
        IRQ = 4'b0000;
        for (int i = 0; i < 4; i++) tick();
        n_cmp++;
        if ({Pending, INT} !== {4'b0010, 1'b0}) begin
            n_bad++; $display("FAIL mask_latched got %b want %b", {Pending, INT}, {4'b0010, 1'b0});
        end
        MaskWe = 1'b1; MaskIn = 4'b0000; tick(); MaskWe = 1'b0;
        tick();
        n_cmp++;
        if ({INT, IntVec} !== {1'b1, 2'd1}) begin
            n_bad++; $display("FAIL mask_release got %b want %b", {INT, IntVec}, {1'b1, 2'd1});
        end
        IntAck = 1'b1; tick(); IntAck = 1'b0;
        IntRet = 1'b1; tick(); IntRet = 1'b0;
        $display("test_mask: masked line latched then released");
    endtask

    task automatic test_gie_drop();
        IRQ = 4'b0001; tick();
        IRQ = 4'b0000; tick(); tick(); tick();
        n_cmp++;
        if ({INT, IntVec} !== {1'b1, 2'd0}) begin
            n_bad++; $display("FAIL gie_req got %b want %b", {INT, IntVec}, {1'b1, 2'd0});
        end
        GieWe = 1'b1; GieIn = 1'b0; tick(); GieWe = 1'b0;
        tick();
        n_cmp++;
        if ({INT, INTD, Pending} !== {1'b0, 1'b1, 4'b0001}) begin
            n_bad++; $display("FAIL gie_drop got %b want %b", {INT, INTD, Pending}, {1'b0, 1'b1, 4'b0001});
        end
        $display("test_gie_drop: request withdrawn, pending kept");
    endtask

    task automatic test_nmi_service();
        int nmi_cnt;
        int nmi_at;
        GieWe = 1'b1; GieIn = 1'b1; tick(); GieWe = 1'b0;
        tick();
        n_cmp++;
        if ({INT, IntVec} !== {1'b1, 2'd0}) begin
            n_bad++; $display("FAIL nmi_setup_req got %b want %b", {INT, IntVec}, {1'b1, 2'd0});
        end
        IntAck = 1'b1; tick(); IntAck = 1'b0;
        GieWe = 1'b1; GieIn = 1'b0; tick(); GieWe = 1'b0;
        NMIIn = 1'b1; tick(); NMIIn = 1'b0;
        nmi_cnt = 0;
        nmi_at  = -1;
        for (int j = 0; j < 6; j++) begin
            tick();
            if (NMI === 1'b1) begin
                nmi_cnt++;
                if (nmi_at < 0) nmi_at = j;
            end
            n_cmp++;
            if ({INT, INTD, Pending} !== {1'b0, 1'b1, 4'b0000}) begin
                n_bad++; $display("FAIL nmi_side_effect cycle %0d got %b want %b", j, {INT, INTD, Pending}, {1'b0, 1'b1, 4'b0000});
            end
        end
        n_cmp++;
        if (nmi_cnt !== 1 || nmi_at !== 1) begin
            n_bad++; $display("FAIL nmi_pulse got count %0d at %0d want count 1 at 1", nmi_cnt, nmi_at);
        end
        IntRet = 1'b1; tick(); IntRet = 1'b0;
        $display("test_nmi_service: single NMI pulse in SERVICE");
    endtask

    task automatic test_back_to_back();
        GieWe = 1'b1; GieIn = 1'b1; tick(); GieWe = 1'b0;
        IRQ = 4'b0100; tick();
        IRQ = 4'b0000; tick(); tick(); tick();
        IRQ = 4'b0100; tick();
        IRQ = 4'b0000; tick();
        IntAck = 1'b1; tick(); IntAck = 1'b0;
        n_cmp++;
        if ({Pending, INT, INTD} !== {4'b0100, 1'b0, 1'b1}) begin
            n_bad++; $display("FAIL b2b_set_wins got %b want %b", {Pending, INT, INTD}, {4'b0100, 1'b0, 1'b1});
        end
        IntRet = 1'b1; tick(); IntRet = 1'b0;
        tick();
        n_cmp++;
        if ({INT, IntVec} !== {1'b1, 2'd2}) begin
            n_bad++; $display("FAIL b2b_rerequest got %b want %b", {INT, IntVec}, {1'b1, 2'd2});
        end
        IntAck = 1'b1; tick(); IntAck = 1'b0;
        IntRet = 1'b1; tick(); IntRet = 1'b0;
        $display("test_back_to_back: edge coinciding with ack");
    endtask

    task automatic test_reset_mid();
        IRQ = 4'b1010; tick();
        IRQ = 4'b0000; tick(); tick(); tick();
        IntAck = 1'b1; tick(); IntAck = 1'b0;
        IRQ = 4'b0010; tick();
        IRQ = 4'b0000; tick(); tick();
        n_cmp++;
        if ({Pending, INTD} !== {4'b1010, 1'b1}) begin
            n_bad++; $display("FAIL midrst_setup got %b want %b", {Pending, INTD}, {4'b1010, 1'b1});
        end
        reset = 1'b1; tick(); reset = 1'b0;
        n_cmp++;
        if ({INT, INTD, NMI, IntVec, Pending} !== 9'b0_1_0_00_0000) begin
            n_bad++; $display("FAIL midrst_state got %b want %b", {INT, INTD, NMI, IntVec, Pending}, 9'b0_1_0_00_0000);
        end
        $display("test_reset_mid: reset during SERVICE");
    endtask

    task automatic test_random(input int cycles);
        logic [8:0] got;
        logic [8:0] exp;
        int         bad_here;
        bad_here = 0;
        for (int c = 0; c < cycles; c++) begin
            reset = ($urandom_range(0, 399) == 0);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0) IRQ[i] = ~IRQ[i];
            end
            if ($urandom_range(0, 11) == 0) NMIIn = ~NMIIn;
            MaskWe = ($urandom_range(0, 15) == 0);
            MaskIn = N'($urandom) & N'($urandom);
            GieWe  = ($urandom_range(0, 15) == 0);
            GieIn  = ($urandom_range(0, 3) != 0);
            IntAck = ($urandom_range(0, 3) == 0);
            IntRet = ($urandom_range(0, 3) == 0);
            tick();
            got = {INT, INTD, NMI, IntVec, Pending};
            exp = {m_int, m_intd, m_nmi, m_vec, m_pend};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                bad_here++;
                $display("FAIL random cycle %0d got %b want %b", c, got, exp);
            end
        end
        reset = 1'b0;
        idle_inputs();
        $display("test_random: %0d cycles, %0d differing", cycles, bad_here);
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_basic();
        test_priority();
        test_mask();
        test_gie_drop();
        test_nmi_service();
        test_back_to_back();
        test_reset_mid();
        test_random(3000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
